// File: rtl/core_bpu_if.sv
// core_bpu_if: fetch lookup, execute resolution and redirect bundle
// for the branch prediction unit.
interface core_bpu_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_num1u;
  logic [XLEN-1:0]  ex_num2u;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_immu;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;

  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_pc,
    input  pred_taken, pred_target,
    output ex_valid, ex_opcode, ex_funct3,
    output ex_num1u, ex_num2u, ex_pc, ex_immu,
    output ex_pred_taken, ex_pred_target,
    input  redirect, redirect_pc,
    input  br_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc,
    output pred_taken, pred_target,
    input  ex_valid, ex_opcode, ex_funct3,
    input  ex_num1u, ex_num2u, ex_pc, ex_immu,
    input  ex_pred_taken, ex_pred_target,
    output redirect, redirect_pc,
    output br_cnt, mispred_cnt
  );
endinterface

// File: rtl/core_bpu.sv
// core_bpu: direct-mapped BTB + 2-bit BHT predictor with execute-side
// resolution, registered redirect, table training and perf counters.
module core_bpu #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input logic       clk,
  input logic       rst_n,
  core_bpu_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             is_jump;
  } btb_t;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BR,
    CF_JAL,
    CF_JALR
  } cf_e;

  logic [ENTRIES-1:0] btb_vld;
  btb_t               btb_mem [ENTRIES];
  logic [1:0]         bht     [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  btb_t             f_ent;
  logic             f_hit;
  logic             f_taken;

  assign f_idx   = bus.if_pc[IDX_W+1:2];
  assign f_tag   = bus.if_pc[XLEN-1:IDX_W+2];
  assign f_ent   = btb_mem[f_idx];
  assign f_hit   = btb_vld[f_idx] && (f_ent.tag == f_tag);
  assign f_taken = f_hit && (f_ent.is_jump || bht[f_idx][1]);

  assign bus.pred_taken  = f_taken;
  assign bus.pred_target = f_taken ? f_ent.target
                                   : bus.if_pc + XLEN'(4);

  cf_e cf;

  always_comb begin
    cf = CF_NONE;
    unique case (1'b1)
      (bus.ex_opcode == OP_BR):   cf = CF_BR;
      (bus.ex_opcode == OP_JAL):  cf = CF_JAL;
      (bus.ex_opcode == OP_JALR): cf = CF_JALR;
      default:                    cf = CF_NONE;
    endcase
  end

  logic eq;
  logic lt;
  logic ltu;
  logic br_cond;

  assign eq  = bus.ex_num1u == bus.ex_num2u;
  assign lt  = $signed(bus.ex_num1u) < $signed(bus.ex_num2u);
  assign ltu = bus.ex_num1u < bus.ex_num2u;

  always_comb begin
    br_cond = 1'b0;
    case (bus.ex_funct3)
      3'b000:  br_cond = eq;
      3'b001:  br_cond = !eq;
      3'b100:  br_cond = lt;
      3'b101:  br_cond = !lt;
      3'b110:  br_cond = ltu;
      3'b111:  br_cond = !ltu;
      default: br_cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            taken;
  logic            is_cf;
  logic            mispred;

  assign pc_rel   = bus.ex_pc + bus.ex_immu;
  assign pc_seq   = bus.ex_pc + XLEN'(4);
  assign jalr_sum = bus.ex_num1u + bus.ex_immu;

  always_comb begin
    taken  = 1'b0;
    target = pc_rel;
    unique case (cf)
      CF_JAL:  taken = 1'b1;
      CF_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      CF_BR:   taken = br_cond;
      default: taken = 1'b0;
    endcase
  end

  assign is_cf   = cf != CF_NONE;
  assign next_pc = taken ? target : pc_seq;
  // a non-branch predicted taken is an alias and also mispredicts
  assign mispred = (bus.ex_pred_taken != taken)
                || (taken && (bus.ex_pred_target != target));

  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic [1:0]       e_cnt;
  logic             btb_wr;
  logic             btb_clr;
  btb_t             btb_wdata;
  logic             bht_wr;
  logic [1:0]       bht_wdata;

  assign e_idx = bus.ex_pc[IDX_W+1:2];
  assign e_tag = bus.ex_pc[XLEN-1:IDX_W+2];
  assign e_cnt = bht[e_idx];

  always_comb begin
    btb_wr    = 1'b0;
    btb_clr   = 1'b0;
    bht_wr    = 1'b0;
    bht_wdata = e_cnt;
    btb_wdata = '{tag: e_tag, target: target,
                  is_jump: (cf != CF_BR)};
    if (bus.ex_valid) begin
      unique case (cf)
        CF_BR: begin
          bht_wr = 1'b1;
          btb_wr = taken;
          if (taken)
            bht_wdata = (e_cnt == 2'b11) ? e_cnt : e_cnt + 2'd1;
          else
            bht_wdata = (e_cnt == 2'b00) ? e_cnt : e_cnt - 2'd1;
        end
        CF_JAL, CF_JALR: begin
          btb_wr    = 1'b1;
          bht_wr    = 1'b1;
          bht_wdata = 2'b11;
        end
        default: btb_clr = bus.ex_pred_taken;
      endcase
    end
  end

  logic             redirect_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld       <= '0;
      for (int i = 0; i < ENTRIES; i++)
        bht[i] <= 2'b01;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      if (btb_wr)
        btb_vld[e_idx] <= 1'b1;
      else if (btb_clr)
        btb_vld[e_idx] <= 1'b0;
      if (bht_wr)
        bht[e_idx] <= bht_wdata;
      redirect_q <= bus.ex_valid && mispred;
      if (bus.ex_valid && mispred) begin
        redirect_pc_q <= next_pc;
        mis_cnt_q     <= mis_cnt_q + CNT_W'(1);
      end
      if (bus.ex_valid && is_cf)
        br_cnt_q <= br_cnt_q + CNT_W'(1);
    end
  end

  // payload is qualified by btb_vld, so it needs no reset
  always_ff @(posedge clk) begin
    if (btb_wr)
      btb_mem[e_idx] <= btb_wdata;
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mispred_cnt = mis_cnt_q;
endmodule

// File: tb/tb_core_bpu.sv
// tb_core_bpu: directed vectors for core_bpu with a queue scoreboard
// checked by an independent negedge monitor.
module tb_core_bpu;
  localparam logic [6:0] BR   = 7'h63;
  localparam logic [6:0] JAL  = 7'h6F;
  localparam logic [6:0] JALR = 7'h67;
  localparam logic [6:0] OPR  = 7'h33;
  localparam logic [6:0] OPI  = 7'h13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_bpu_if #(.XLEN(32), .CNT_W(32)) bus ();

  core_bpu #(
    .XLEN(32),
    .ENTRIES(64),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        rd;
    logic [31:0] pc;
  } rd_exp_t;

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] br;
    logic [31:0] mis;
  } pr_exp_t;

  rd_exp_t rd_q[$];
  pr_exp_t pr_q[$];
  int      total = 0;
  int      bad = 0;
  logic    probe = 1'b0;
  logic    ex_vld_d;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ex_vld_d <= 1'b0;
    else        ex_vld_d <= bus.ex_valid;

  rd_exp_t re;
  pr_exp_t pe;

  always @(negedge clk) begin
    if (ex_vld_d) begin
      if (rd_q.size() == 0) begin
        chk("rd_q_underflow", 32'd1, 32'd0);
      end else begin
        re = rd_q.pop_front();
        chk("redirect", {31'd0, bus.redirect}, {31'd0, re.rd});
        if (re.rd)
          chk("redirect_pc", bus.redirect_pc, re.pc);
      end
    end else if (bus.redirect) begin
      chk("spurious_redirect", 32'd1, 32'd0);
    end
    if (probe) begin
      if (pr_q.size() == 0) begin
        chk("pr_q_underflow", 32'd1, 32'd0);
      end else begin
        pe = pr_q.pop_front();
        chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, pe.tk});
        chk("pred_target", bus.pred_target, pe.tgt);
        chk("br_cnt", bus.br_cnt, pe.br);
        chk("mispred_cnt", bus.mispred_cnt, pe.mis);
      end
    end
  end

  task automatic ex_op(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] n1, input logic [31:0] n2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic erd, input logic [31:0] epc);
    bus.ex_valid       = 1'b1;
    bus.ex_opcode      = op;
    bus.ex_funct3      = f3;
    bus.ex_num1u       = n1;
    bus.ex_num2u       = n2;
    bus.ex_pc          = pc;
    bus.ex_immu        = imm;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    rd_q.push_back('{rd: erd, pc: epc});
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic probe_pc(input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic [31:0] br,
                          input logic [31:0] mis);
    bus.if_pc = pc;
    pr_q.push_back('{tk: tk, tgt: tgt, br: br, mis: mis});
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.if_pc          = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_opcode      = '0;
    bus.ex_funct3      = '0;
    bus.ex_num1u       = '0;
    bus.ex_num2u       = '0;
    bus.ex_pc          = '0;
    bus.ex_immu        = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    probe_pc(32'h100, 0, 32'h104, 0, 0);
    // BEQ taken, predicted not taken; BHT 01 -> 10
    ex_op(BR, 3'b000, 5, 5, 32'h100, 32'h40, 0, 0, 1, 32'h140);
    probe_pc(32'h100, 1, 32'h140, 1, 1);
    ex_op(BR, 3'b000, 5, 5, 32'h100, 32'h40, 1, 32'h140, 0, 0);
    probe_pc(32'h100, 1, 32'h140, 2, 1);
    // BNE not taken twice: 11 -> 10 -> 01
    ex_op(BR, 3'b001, 5, 5, 32'h100, 32'h40, 1, 32'h140, 1, 32'h104);
    probe_pc(32'h100, 1, 32'h140, 3, 2);
    ex_op(BR, 3'b001, 5, 5, 32'h100, 32'h40, 1, 32'h140, 1, 32'h104);
    probe_pc(32'h100, 0, 32'h104, 4, 3);
    // funct3 010/011 never taken; counter saturates at 00
    ex_op(BR, 3'b010, 5, 5, 32'h100, 32'h40, 0, 0, 0, 0);
    ex_op(BR, 3'b011, 5, 5, 32'h100, 32'h40, 0, 0, 0, 0);
    ex_op(BR, 3'b000, 7, 7, 32'h100, 32'h40, 0, 0, 1, 32'h140);
    ex_op(BR, 3'b000, 7, 7, 32'h100, 32'h40, 0, 0, 1, 32'h140);
    probe_pc(32'h100, 1, 32'h140, 8, 5);
    // signed vs unsigned compare, both correctly predicted
    ex_op(BR, 3'b100, 32'hFFFF_FFFF, 1, 32'h204, 32'h20,
          1, 32'h224, 0, 0);
    ex_op(BR, 3'b110, 32'hFFFF_FFFF, 1, 32'h208, 32'h20,
          0, 0, 0, 0);
    probe_pc(32'h208, 0, 32'h20C, 10, 5);
    probe_pc(32'h204, 1, 32'h224, 10, 5);
    // JALR clears LSB and installs a jump entry
    ex_op(JALR, 3'b000, 32'h201, 0, 32'h310, 0, 0, 0, 1, 32'h200);
    probe_pc(32'h310, 1, 32'h200, 11, 6);
    // JAL with wrong predicted target
    ex_op(JAL, 3'b000, 0, 0, 32'h320, 32'hFFFF_FFE0,
          1, 32'h400, 1, 32'h300);
    probe_pc(32'h320, 1, 32'h300, 12, 7);
    // target wraps modulo 2^32
    ex_op(JAL, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'h20, 0, 0, 1, 32'h10);
    probe_pc(32'hFFFF_FFF0, 1, 32'h10, 13, 8);
    // alias: non-branch predicted taken
    ex_op(OPR, 3'b000, 0, 0, 32'h100, 0, 1, 32'h140, 1, 32'h104);
    probe_pc(32'h100, 0, 32'h104, 13, 9);
    ex_op(OPI, 3'b000, 0, 0, 32'h104, 0, 0, 0, 0, 0);
    probe_pc(32'h104, 0, 32'h108, 13, 9);
    repeat (2) @(posedge clk);
    #1;

    // reset while a mispredict redirect is on the output
    bus.ex_valid       = 1'b1;
    bus.ex_opcode      = BR;
    bus.ex_funct3      = 3'b000;
    bus.ex_num1u       = 32'd1;
    bus.ex_num2u       = 32'd2;
    bus.ex_pc          = 32'h204;
    bus.ex_immu        = 32'h20;
    bus.ex_pred_taken  = 1'b1;
    bus.ex_pred_target = 32'h224;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("abort_redirect_pc", bus.redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    probe_pc(32'h204, 0, 32'h208, 0, 0);
    probe_pc(32'h310, 0, 32'h314, 0, 0);
    probe_pc(32'hFFFF_FFF0, 0, 32'hFFFF_FFF4, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("pr_q_drained", pr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
